shift_window_ctrl: RTL and testbench

Sequences the 32-bit pixel-word shift chain (shift_2 stages, one per window row) for the edge detector. It accepts a frame of pixel words over a valid/ready stream and generates the shift enable for every accepted word. It tracks column and row positions and flags when a full 3x3 window is present, with centre coordinates, for the Sobel stage. It also handles downstream backpressure and frame start/completion.

---
 rtl/edge_pkg.sv | 24 ++
 rtl/shift_window_ctrl_if.sv | 40 ++++
 rtl/window_pos_counter.sv | 65 ++++++
 rtl/shift_window_ctrl.sv | 165 ++++++++++++++++
 tb/tb_shift_window_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detector window sequencing logic:
// controller state encoding, minimum usable frame dimension and
// default counter widths.
package edge_pkg;

  localparam int COL_W_DEF = 10;
  localparam int ROW_W_DEF = 10;

  // A 3x3 Sobel window needs at least three columns and three rows.
  localparam int WIN_MIN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // True when a frame dimension is large enough to ever hold a full window.
  function automatic logic dim_ok(input logic [31:0] dim);
    return (dim >= 32'(WIN_MIN));
  endfunction

endpackage

// File: rtl/shift_window_ctrl_if.sv
// Pixel-word stream and window hand-off between upstream, the shift
// controller and the Sobel stage.
interface shift_window_ctrl_if
  import edge_pkg::*;
#(
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             out_ready;
  logic             win_valid;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;

  // Environment side: supplies pixel words and consumes windows.
  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  shift_en,
    input  win_valid,
    input  win_col,
    input  win_row
  );

  // Controller side.
  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output shift_en,
    output win_valid,
    output win_col,
    output win_row
  );

endinterface

// File: rtl/window_pos_counter.sv
// Raster position of the next accepted pixel word. Column wraps at the
// latched frame width and carries into the row. Also reports whether the
// current position is the last word of the frame and whether a word at
// this position completes a 3x3 window.
module window_pos_counter
  import edge_pkg::*;
#(
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  input  logic [COL_W-1:0] cfg_width,
  input  logic [ROW_W-1:0] cfg_height,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last,
  output logic             qualify
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_wrap_s;

  assign col_wrap_s = (col_q == (cfg_width - COL_W'(1)));

  // Next position: clear on frame start, advance on each accepted word.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = COL_W'(0);
      row_d = ROW_W'(0);
    end else if (inc) begin
      if (col_wrap_s) begin
        col_d = COL_W'(0);
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= COL_W'(0);
      row_q <= ROW_W'(0);
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col     = col_q;
  assign row     = row_q;
  assign last    = col_wrap_s && (row_q == (cfg_height - ROW_W'(1)));
  assign qualify = (col_q >= COL_W'(2)) && (row_q >= ROW_W'(2));

endmodule

// File: rtl/shift_window_ctrl.sv
// Sequences the 2-deep pixel-word shift chain for the edge detector:
// accepts a frame over valid/ready, fires the shift enable per accepted
// word, and presents each complete 3x3 window (centre coordinates) to the
// Sobel stage with backpressure.
module shift_window_ctrl
  import edge_pkg::*;
#(
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [COL_W-1:0]    cfg_width,
  input  logic [ROW_W-1:0]    cfg_height,
  shift_window_ctrl_if.slave  bus,
  output logic                busy,
  output logic                frame_done,
  output logic                err_cfg
);

  state_e           state_q, state_d;
  logic [COL_W-1:0] cfg_w_q, cfg_w_d;
  logic [ROW_W-1:0] cfg_h_q, cfg_h_d;
  logic             win_valid_q, win_valid_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             err_cfg_q, err_cfg_d;

  logic             in_ready_s;
  logic             shift_en_s;
  logic             cnt_clear_s;
  logic [COL_W-1:0] pos_col_s;
  logic [ROW_W-1:0] pos_row_s;
  logic             pos_last_s;
  logic             pos_qualify_s;

  window_pos_counter #(
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (shift_en_s),
    .clear     (cnt_clear_s),
    .cfg_width (cfg_w_q),
    .cfg_height(cfg_h_q),
    .col       (pos_col_s),
    .row       (pos_row_s),
    .last      (pos_last_s),
    .qualify   (pos_qualify_s)
  );

  // Accept a word only while running and the window slot is free or being consumed.
  always_comb begin
    in_ready_s = 1'b0;
    if (state_q == ST_RUN) begin
      in_ready_s = (!win_valid_q) || bus.out_ready;
    end else begin
      in_ready_s = 1'b0;
    end
    shift_en_s = bus.in_valid && in_ready_s;
  end

  // Frame sequencing: start validation, run, drain the last window, done pulse.
  always_comb begin
    state_d     = state_q;
    cfg_w_d     = cfg_w_q;
    cfg_h_d     = cfg_h_q;
    cnt_clear_s = 1'b0;
    err_cfg_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dim_ok(32'(cfg_width)) && dim_ok(32'(cfg_height))) begin
            cfg_w_d     = cfg_width;
            cfg_h_d     = cfg_height;
            cnt_clear_s = 1'b1;
            state_d     = ST_RUN;
          end else begin
            err_cfg_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (shift_en_s && pos_last_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!win_valid_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // Window slot: load on a qualifying accepted word, clear when consumed.
  // A load in the same cycle as a consumption simply replaces the window.
  always_comb begin
    win_valid_d = win_valid_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    if (shift_en_s && pos_qualify_s) begin
      win_valid_d = 1'b1;
      win_col_d   = pos_col_s - COL_W'(1);
      win_row_d   = pos_row_s - ROW_W'(1);
    end else if (win_valid_q && bus.out_ready) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_w_q      <= COL_W'(0);
      cfg_h_q      <= ROW_W'(0);
      win_valid_q  <= 1'b0;
      win_col_q    <= COL_W'(0);
      win_row_q    <= ROW_W'(0);
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_cfg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_w_q      <= cfg_w_d;
      cfg_h_q      <= cfg_h_d;
      win_valid_q  <= win_valid_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_cfg_q    <= err_cfg_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.shift_en  = shift_en_s;
  assign bus.win_valid = win_valid_q;
  assign bus.win_col   = win_col_q;
  assign bus.win_row   = win_row_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign err_cfg       = err_cfg_q;

endmodule

// File: tb/tb_shift_window_ctrl.sv
// Randomized self-checking bench for shift_window_ctrl. The reference model
// works from raster word index: word k sits at (k % W, k / W), and every word
// with col>=2 and row>=2 yields a window centred one up and one left. Those
// expected windows are queued and matched against each consumed window.
module tb_shift_window_ctrl;
  import edge_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] cfg_width;
  logic [9:0] cfg_height;
  logic       busy;
  logic       frame_done;
  logic       err_cfg;

  int checks   = 0;
  int failures = 0;

  shift_window_ctrl_if bus ();

  shift_window_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_width (cfg_width),
    .cfg_height(cfg_height),
    .bus       (bus.slave),
    .busy      (busy),
    .frame_done(frame_done),
    .err_cfg   (err_cfg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Run one frame. vmode: 0 valid always, 1 toggling, 2 random.
  // rmode: 0 ready always, 1 random, 2 held low for 5 cycles after first window.
  // abort_words > 0 returns once that many words were accepted.
  task automatic run_frame(input int w, input int h, input int vmode, input int rmode,
                           input int abort_words, input bit inject_start);
    int   acc = 0;
    int   last_shift = -1;
    int   done_cyc = -1;
    int   ndone = 0;
    int   nwin = 0;
    int   win_cycles = 0;
    int   seen_win = -1;
    int   budget;
    int   eq_c[$];
    int   eq_r[$];
    bit   held = 1'b0;
    bit   finished = 1'b0;
    int   held_c = 0;
    int   held_r = 0;
    budget = w * h * 12 + 60;

    @(posedge clk); #1;
    start = 1'b1; cfg_width = 10'(w); cfg_height = 10'(h);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      if (abort_words > 0 && acc >= abort_words) return;
      // cfg inputs are changed freely mid-frame; they must have no effect
      cfg_width  = 10'($urandom_range(2, 9));
      cfg_height = 10'($urandom_range(2, 9));
      start = (inject_start && cyc == 3);
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (cyc % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (seen_win >= 0 && cyc >= seen_win + 5);
      endcase

      @(negedge clk);
      check("shift_en", 32'(bus.shift_en), 32'(bus.in_valid & bus.in_ready));
      check("no_err_cfg", 32'(err_cfg), 0);
      check("busy_frame", 32'(busy), 1);
      if (acc == w * h)
        check("in_ready_drain", 32'(bus.in_ready), 0);
      else
        check("in_ready_run", 32'(bus.in_ready), 32'(!bus.win_valid || bus.out_ready));
      if (held) begin
        check("hold_valid", 32'(bus.win_valid), 1);
        check("hold_col", 32'(bus.win_col), held_c);
        check("hold_row", 32'(bus.win_row), held_r);
      end
      if (bus.win_valid) begin
        win_cycles++;
        if (seen_win < 0) seen_win = cyc;
        if (bus.out_ready) begin
          if (eq_c.size() == 0) begin
            check("win_unexpected", 1, 0);
          end else begin
            check("win_col", 32'(bus.win_col), eq_c.pop_front());
            check("win_row", 32'(bus.win_row), eq_r.pop_front());
            nwin++;
          end
        end
      end
      held   = bus.win_valid && !bus.out_ready;
      held_c = int'(bus.win_col);
      held_r = int'(bus.win_row);
      if (bus.shift_en) begin
        if ((acc % w) >= 2 && (acc / w) >= 2) begin
          eq_c.push_back((acc % w) - 1);
          eq_r.push_back((acc / w) - 1);
        end
        if (acc == w * h - 1) last_shift = cyc;
        acc++;
      end
      if (frame_done) begin
        ndone++;
        done_cyc = cyc;
        finished = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end

    if (finished) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("done_single", 32'(frame_done), 0);
      check("busy_after", 32'(busy), 0);
      check("in_ready_idle", 32'(bus.in_ready), 0);
    end
    check("words", acc, w * h);
    check("windows", nwin, (w - 2) * (h - 2));
    check("frame_done_cnt", ndone, 1);
    check("win_left", eq_c.size(), 0);
    if (rmode == 0) begin
      check("done_latency", done_cyc - last_shift, 3);
      check("win_cycles", win_cycles, nwin);
    end
  endtask

  // Rejected start: one-cycle err_cfg, controller stays idle.
  task automatic err_start(input int w, input int h);
    @(posedge clk); #1;
    start = 1'b1; cfg_width = 10'(w); cfg_height = 10'(h); bus.in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(err_cfg), 1);
    check("err_busy", 32'(busy), 0);
    check("err_in_ready", 32'(bus.in_ready), 0);
    check("err_shift_en", 32'(bus.shift_en), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_pulse_end", 32'(err_cfg), 0);
    check("err_busy2", 32'(busy), 0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_width = 10'd0; cfg_height = 10'd0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_win_valid", 32'(bus.win_valid), 0);
    check("rst_win_col", 32'(bus.win_col), 0);
    check("rst_win_row", 32'(bus.win_row), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_err_cfg", 32'(err_cfg), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed frames
    run_frame(4, 3, 0, 0, 0, 1'b0);
    run_frame(3, 3, 0, 2, 0, 1'b0);
    run_frame(5, 4, 1, 0, 0, 1'b0);
    err_start(2, 10);
    err_start(5, 1);
    run_frame(3, 3, 0, 0, 0, 1'b0);

    // Reset in the middle of a 4x4 frame
    run_frame(4, 4, 0, 0, 7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_win_valid", 32'(bus.win_valid), 0);
    check("arst_win_col", 32'(bus.win_col), 0);
    check("arst_win_row", 32'(bus.win_row), 0);
    check("arst_in_ready", 32'(bus.in_ready), 0);
    check("arst_shift_en", 32'(bus.shift_en), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", 32'(frame_done), 0);
    end
    rst_n = 1'b1;
    run_frame(4, 4, 0, 0, 0, 1'b0);

    // start during RUN is ignored
    run_frame(4, 3, 0, 0, 0, 1'b1);

    // Randomized frames
    for (int n = 0; n < 8; n++) begin
      run_frame(int'($urandom_range(3, 7)), int'($urandom_range(3, 5)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
